// File: rtl/hdmi_timing_if.sv
// Video timing bundle: renderer request/return path plus the encoder-facing outputs.
// The controller takes the master side; renderer, encoders and bench take the slave side.
interface hdmi_timing_if;
  logic        run;
  logic [15:0] pix_data;
  logic        pix_req;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [7:0]  rgb_r;
  logic [7:0]  rgb_g;
  logic [7:0]  rgb_b;
  logic        frame_start;
  logic        active;

  modport master (
    input  run, pix_data,
    output pix_req, pix_x, pix_y, de, hsync, vsync,
    output rgb_r, rgb_g, rgb_b, frame_start, active
  );

  modport slave (
    output run, pix_data,
    input  pix_req, pix_x, pix_y, de, hsync, vsync,
    input  rgb_r, rgb_g, rgb_b, frame_start, active
  );
endinterface

// File: rtl/hdmi_timing_ctrl.sv
// HDMI video timing controller: h/v counters, sync/de generation and RGB565->RGB888 return path.
// Optional HDMI_TEST_PATTERN_EN replaces renderer pixels with 8 vertical colour bars.
module hdmi_timing_ctrl #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  hdmi_timing_if.master bus
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_B12  = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] V_ACT_B12  = 12'(V_SYNC + V_BACK);
  // 13-bit bounds so an active area ending exactly at 4096 still compares correctly
  localparam logic [12:0] H_SYNC_E   = 13'(H_SYNC);
  localparam logic [12:0] V_SYNC_E   = 13'(V_SYNC);
  localparam logic [12:0] H_ACT_B    = 13'(H_SYNC + H_BACK);
  localparam logic [12:0] H_ACT_E    = 13'(H_SYNC + H_BACK + H_VALID);
  localparam logic [12:0] V_ACT_B    = 13'(V_SYNC + V_BACK);
  localparam logic [12:0] V_ACT_E    = 13'(V_SYNC + V_BACK + V_VALID);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_h_q, cnt_h_d;
  logic [11:0] cnt_v_q, cnt_v_d;

  logic        pix_req_q, hs1_q, vs1_q, fs1_q, active_q;
  logic [11:0] pix_x_q, pix_y_q;
  logic        de_q, hsync_q, vsync_q, frame_start_q;
  logic [23:0] rgb_q;

  logic        run_s, h_end_s, v_end_s, h_sync_s, v_sync_s, h_act_s, v_act_s, req_s;
  logic [23:0] rgb_s;

  function automatic logic [23:0] rgb565_expand(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  assign run_s    = (state_q == RUN);
  assign h_end_s  = (cnt_h_q == H_LAST);
  assign v_end_s  = (cnt_v_q == V_LAST);
  assign h_sync_s = ({1'b0, cnt_h_q} < H_SYNC_E);
  assign v_sync_s = ({1'b0, cnt_v_q} < V_SYNC_E);
  assign h_act_s  = ({1'b0, cnt_h_q} >= H_ACT_B) && ({1'b0, cnt_h_q} < H_ACT_E);
  assign v_act_s  = ({1'b0, cnt_v_q} >= V_ACT_B) && ({1'b0, cnt_v_q} < V_ACT_E);
  assign req_s    = run_s & h_act_s & v_act_s;

  // Next state and counters; leaving RUN is only allowed on the last pixel of a frame
  always_comb begin
    state_d = state_q;
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    case (state_q)
      IDLE: begin
        cnt_h_d = 12'd0;
        cnt_v_d = 12'd0;
        if (bus.run) state_d = RUN;
        else         state_d = IDLE;
      end
      RUN: begin
        if (h_end_s) begin
          cnt_h_d = 12'd0;
          if (v_end_s) begin
            cnt_v_d = 12'd0;
            if (bus.run) state_d = RUN;
            else         state_d = IDLE;
          end else begin
            cnt_v_d = cnt_v_q + 12'd1;
          end
        end else begin
          cnt_h_d = cnt_h_q + 12'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_h_d = 12'd0;
        cnt_v_d = 12'd0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_h_q <= 12'd0;
      cnt_v_q <= 12'd0;
    end else begin
      state_q <= state_d;
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  // Stage 1: pixel request and region decodes
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_req_q <= 1'b0;
      pix_x_q   <= 12'd0;
      pix_y_q   <= 12'd0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      fs1_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      pix_req_q <= req_s;
      pix_x_q   <= req_s ? (cnt_h_q - H_ACT_B12) : 12'd0;
      pix_y_q   <= req_s ? (cnt_v_q - V_ACT_B12) : 12'd0;
      hs1_q     <= run_s & h_sync_s;
      vs1_q     <= run_s & v_sync_s;
      fs1_q     <= run_s & (cnt_h_q == 12'd0) & (cnt_v_q == 12'd0);
      active_q  <= run_s;
    end
  end

`ifdef HDMI_TEST_PATTERN_EN
  localparam logic [11:0] BAR_LAST = 12'(H_VALID / 8 - 1);
  logic [11:0] bar_cnt_q;
  logic [2:0]  bar_idx_q;

  // Bar index tracks the stage-1 pixel; restarted on each line's first active pixel
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bar_cnt_q <= 12'd0;
      bar_idx_q <= 3'd0;
    end else if (req_s) begin
      if (cnt_h_q == H_ACT_B12) begin
        bar_cnt_q <= 12'd0;
        bar_idx_q <= 3'd0;
      end else if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_q <= 12'd0;
        bar_idx_q <= bar_idx_q + 3'd1;
      end else begin
        bar_cnt_q <= bar_cnt_q + 12'd1;
      end
    end else begin
      bar_cnt_q <= bar_cnt_q;
      bar_idx_q <= bar_idx_q;
    end
  end

  assign rgb_s = pix_req_q ? bar_rgb(bar_idx_q) : 24'd0;
`else
  assign rgb_s = pix_req_q ? rgb565_expand(bus.pix_data) : 24'd0;
`endif

  // Stage 2: encoder-facing outputs, all mutually aligned
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      de_q          <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= 24'd0;
    end else begin
      de_q          <= pix_req_q;
      hsync_q       <= hs1_q;
      vsync_q       <= vs1_q;
      frame_start_q <= fs1_q;
      rgb_q         <= rgb_s;
    end
  end

  assign bus.pix_req     = pix_req_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.de          = de_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.frame_start = frame_start_q;
  assign bus.active      = active_q;
  assign bus.rgb_r       = rgb_q[23:16];
  assign bus.rgb_g       = rgb_q[15:8];
  assign bus.rgb_b       = rgb_q[7:0];

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Self-checking bench for hdmi_timing_ctrl using a reduced video mode and a frame-position model.
// Works with or without HDMI_TEST_PATTERN_EN.
module tb_hdmi_timing_ctrl;
  localparam int HS = 4, HB = 3, HV = 16, HF = 2;
  localparam int VS = 2, VB = 2, VV = 4, VF = 1;
  localparam int HT = HS + HB + HV + HF;
  localparam int VT = VS + VB + VV + VF;
  localparam int FT = HT * VT;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  hdmi_timing_if bus();

  hdmi_timing_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  // Renderer: address-to-data lookup, sampled by the controller one cycle after the request
  assign bus.pix_data = {bus.pix_x[4:0], bus.pix_y[5:0], 5'h1F};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: frame position (0..FT-1) of the counters, -1 when idle, plus two cycles of history
  int m0, m1, m2;

  function automatic int nxt(int p, logic r);
    if (p < 0 || p == FT - 1) return r ? 0 : -1;
    return p + 1;
  endfunction

  function automatic bit in_act(int p);
    int h, v;
    if (p < 0) return 1'b0;
    h = p % HT;
    v = p / HT;
    return (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
  endfunction

  function automatic logic [23:0] pix_rgb(int x, int y);
`ifdef HDMI_TEST_PATTERN_EN
    logic [23:0] c;
    case (x / (HV / 8))
      0: c = 24'hFFFFFF;
      1: c = 24'hFFFF00;
      2: c = 24'h00FFFF;
      3: c = 24'h00FF00;
      4: c = 24'hFF00FF;
      5: c = 24'hFF0000;
      6: c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
`else
    logic [15:0] d;
    logic [4:0]  x5;
    logic [5:0]  y6;
    x5 = x[4:0];
    y6 = y[5:0];
    d  = {x5, y6, 5'h1F};
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
`endif
  endfunction

  function automatic logic [24:0] exp1(int p);
    if (in_act(p)) return {1'b1, 12'(p % HT - HS - HB), 12'(p / HT - VS - VB)};
    return 25'd0;
  endfunction

  function automatic logic [27:0] exp2(int p);
    logic de, hs, vs, fs;
    logic [23:0] c;
    if (p < 0) return 28'd0;
    de = in_act(p);
    hs = (p % HT) < HS;
    vs = (p / HT) < VS;
    fs = (p == 0);
    c  = de ? pix_rgb(p % HT - HS - HB, p / HT - VS - VB) : 24'd0;
    return {de, hs, vs, fs, c};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= -1;
      m1 <= -1;
      m2 <= -1;
    end else begin
      m0 <= nxt(m0, bus.run);
      m1 <= m0;
      m2 <= m1;
    end
  end

  task automatic test_reset();
    bus.run = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.pix_req, bus.pix_x, bus.pix_y, bus.de, bus.hsync, bus.vsync, bus.rgb_r, bus.rgb_g,
           bus.rgb_b, bus.frame_start, bus.active} !== 66'd0) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d req=%b de=%b hs=%b vs=%b fs=%b act=%b (all required 0)",
                 i, bus.pix_req, bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.active);
      end
    end
  endtask

  task automatic test_start_pulse();
    int de_cnt = 0;
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.hsync, bus.frame_start} !== 2'b00) begin
      errors++;
      $display("FAIL start_early hs/fs=%b required 00", {bus.hsync, bus.frame_start});
    end
    @(negedge clk);
    checks++;
    if ({bus.hsync, bus.vsync, bus.frame_start} !== 3'b111) begin
      errors++;
      $display("FAIL start_latency hs/vs/fs=%b required 111", {bus.hsync, bus.vsync, bus.frame_start});
    end
    for (int i = 0; i < FT + 4; i++) begin
      de_cnt += int'(bus.de);
      @(negedge clk);
    end
    checks++;
    if (de_cnt != HV * VV) begin
      errors++;
      $display("FAIL pulse_frame_de got=%0d required=%0d", de_cnt, HV * VV);
    end
    checks++;
    if (bus.active !== 1'b0) begin
      errors++;
      $display("FAIL pulse_back_idle active=%b required 0", bus.active);
    end
  endtask

  task automatic test_frame_counts();
    int n = 0;
    int hs_tot = 0, de_tot = 0, vs_tot = 0, fs_cnt = 0;
    int hs_rise0 = -1, hs_rise1 = -1, de_rise0 = -1, fs_t1 = -1;
    int run_len = 0, max_run = 0;
    logic prev_hs = 1'b0, prev_de = 1'b0;
    bus.run = 1'b1;
    while (bus.frame_start !== 1'b1 && n < 2 * FT + 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL counts_wait_fs timeout after %0d cycles", n);
    end
    for (int t = 0; t < 2 * FT; t++) begin
      hs_tot += int'(bus.hsync);
      de_tot += int'(bus.de);
      vs_tot += int'(bus.vsync);
      if (bus.frame_start && t > 0) begin
        fs_cnt++;
        fs_t1 = t;
      end
      if (bus.hsync && !prev_hs) begin
        if (hs_rise0 < 0) hs_rise0 = t;
        else if (hs_rise1 < 0) hs_rise1 = t;
      end
      if (bus.de && !prev_de && de_rise0 < 0) begin
        de_rise0 = t;
        checks++;
        if (bus.rgb_b !== 8'hFF) begin
          errors++;
          $display("FAIL pixel00_blue got=%h required=ff", bus.rgb_b);
        end
      end
      run_len = bus.de ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      prev_hs = bus.hsync;
      prev_de = bus.de;
      @(negedge clk);
    end
    checks++;
    if (hs_tot != 2 * VT * HS) begin
      errors++; $display("FAIL hsync_total got=%0d required=%0d", hs_tot, 2 * VT * HS);
    end
    checks++;
    if (de_tot != 2 * HV * VV) begin
      errors++; $display("FAIL de_total got=%0d required=%0d", de_tot, 2 * HV * VV);
    end
    checks++;
    if (vs_tot != 2 * VS * HT) begin
      errors++; $display("FAIL vsync_total got=%0d required=%0d", vs_tot, 2 * VS * HT);
    end
    checks++;
    if (hs_rise1 - hs_rise0 != HT) begin
      errors++; $display("FAIL line_period got=%0d required=%0d", hs_rise1 - hs_rise0, HT);
    end
    checks++;
    if (de_rise0 - hs_rise0 != (VS + VB) * HT + HS + HB) begin
      errors++;
      $display("FAIL de_offset got=%0d required=%0d", de_rise0 - hs_rise0, (VS + VB) * HT + HS + HB);
    end
    checks++;
    if (fs_cnt != 1 || fs_t1 != FT) begin
      errors++; $display("FAIL frame_period count=%0d at=%0d required 1 at %0d", fs_cnt, fs_t1, FT);
    end
    checks++;
    if (max_run != HV) begin
      errors++; $display("FAIL de_run_length got=%0d required=%0d", max_run, HV);
    end
  endtask

  task automatic test_stop_midframe();
    int n = 0, de_cnt = 0, fs_cnt = 0, bad = 0;
    localparam int P = (VS + VB + 2) * HT + HS + HB;
    while (!(bus.pix_req === 1'b1 && bus.pix_y === 12'd2 && bus.pix_x === 12'd0) && n < 2 * FT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2 * FT) begin
      errors++; $display("FAIL stop_wait_row2 timeout after %0d cycles", n);
    end
    bus.run = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      de_cnt += int'(bus.de);
      fs_cnt += int'(bus.frame_start);
    end while (bus.active !== 1'b0 && n < 2 * FT);
    checks++;
    if (n != FT - P) begin
      errors++; $display("FAIL stop_frame_end cycles=%0d required=%0d", n, FT - P);
    end
    checks++;
    if (de_cnt != (VV - 2) * HV || fs_cnt != 0) begin
      errors++;
      $display("FAIL stop_tail de=%0d fs=%0d required de=%0d fs=0", de_cnt, fs_cnt, (VV - 2) * HV);
    end
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge clk);
      bad += int'(bus.de | bus.frame_start | bus.pix_req | bus.active);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stop_stays_idle busy_cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    bus.run = 1'b1;
    while (bus.de !== 1'b1 && n < 2 * FT + 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.de !== 1'b1) begin
      errors++; $display("FAIL rstmid_wait_de timeout after %0d cycles", n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.de, bus.hsync, bus.vsync, bus.rgb_r, bus.rgb_g, bus.rgb_b, bus.pix_req, bus.active} !== 29'd0) begin
      errors++;
      $display("FAIL rstmid_async de=%b hs=%b vs=%b rgb=%h%h%h (all required 0)",
               bus.de, bus.hsync, bus.vsync, bus.rgb_r, bus.rgb_g, bus.rgb_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b0) begin
      errors++; $display("FAIL rstmid_fs_early fs=%b required 0", bus.frame_start);
    end
    @(negedge clk);
    checks++;
    if ({bus.frame_start, bus.hsync, bus.vsync} !== 3'b111) begin
      errors++;
      $display("FAIL rstmid_restart fs/hs/vs=%b required 111", {bus.frame_start, bus.hsync, bus.vsync});
    end
  endtask

  task automatic test_random_run();
    logic [24:0] e1;
    logic [27:0] e2;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      e1 = exp1(m1);
      e2 = exp2(m2);
      checks++;
      if ({bus.pix_req, bus.pix_x, bus.pix_y} !== e1) begin
        errors++;
        $display("FAIL random_req t=%0d got=%h required=%h", t, {bus.pix_req, bus.pix_x, bus.pix_y}, e1);
      end
      checks++;
      if ({bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.rgb_r, bus.rgb_g, bus.rgb_b} !== e2) begin
        errors++;
        $display("FAIL random_video t=%0d got=%h required=%h", t,
                 {bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.rgb_r, bus.rgb_g, bus.rgb_b}, e2);
      end
      checks++;
      if (bus.active !== (m1 >= 0)) begin
        errors++; $display("FAIL random_active t=%0d got=%b required=%b", t, bus.active, m1 >= 0);
      end
      if ($urandom_range(0, 149) == 0) bus.run = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_pixel_colours();
    int n = 0;
    int pick;
    logic [23:0] line_rgb [HV];
    bus.run = 1'b1;
    while (bus.frame_start !== 1'b1 && n < 3 * FT) begin
      @(negedge clk);
      n++;
    end
    while (bus.de !== 1'b1 && n < 5 * FT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.de !== 1'b1) begin
      errors++; $display("FAIL pixel_wait_de timeout after %0d cycles", n);
    end
    for (int i = 0; i < HV; i++) begin
      line_rgb[i] = {bus.rgb_r, bus.rgb_g, bus.rgb_b};
      @(negedge clk);
    end
    pick = int'($urandom_range(1, HV - 2));
    foreach (line_rgb[i]) begin
      if (i == 0 || i == HV / 8 || i == HV - 1 || i == pick) begin
        checks++;
        if (line_rgb[i] !== pix_rgb(i, 0)) begin
          errors++; $display("FAIL pixel_rgb x=%0d got=%h required=%h", i, line_rgb[i], pix_rgb(i, 0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_pulse();
    test_frame_counts();
    test_stop_midframe();
    test_reset_midframe();
    test_random_run();
    test_pixel_colours();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hdmi_timing_ctrl.md
# hdmi_timing_ctrl

Video timing controller that sequences the per-channel TMDS encoders. It generates the horizontal and vertical counters, the HSYNC and VSYNC control signals (fed to the blue-channel c0/c1) and the data-enable (fed to every encoder's de). It requests pixels from the game renderer and returns them as 8-bit-per-channel RGB, aligned with de. It sits between the snake renderer (pixel source) and the three encoder instances.

## Interface
Parameters:
- H_SYNC, 96, hsync width in pixel clocks
- H_BACK, 48, horizontal back porch
- H_VALID, 640, active pixels per line (multiple of 8)
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch
- V_VALID, 480, active lines
- V_FRONT, 10, vertical front porch

Ports (clock: one, sys_clk; reset: sys_rst_n, asynchronous, active-low):
- sys_clk  in  1  pixel clock
- sys_rst_n  in  1  asynchronous active-low reset
- run  in  1  level; request timing generation
- pix_data  in  16  RGB565 from renderer, valid 1 cycle after pix_req
- pix_req  out  1  pixel fetch strobe
- pix_x  out  12  active-area column of request, 0..H_VALID-1
- pix_y  out  12  active-area row of request, 0..V_VALID-1
- de  out  1  to encoder de
- hsync  out  1  to blue encoder c0, active high
- vsync  out  1  to blue encoder c1, active high
- rgb_r / rgb_g / rgb_b  out  8 each  to encoder data_in
- frame_start  out  1  one-cycle pulse at counter (0,0)
- active  out  1  controller in RUN

## Operation
- Totals: H_TOTAL = H_SYNC+H_BACK+H_VALID+H_FRONT, V_TOTAL likewise. Both must be ≤ 4096. Counters cnt_h and cnt_v are 12-bit unsigned.
- State machine with two states:
  - IDLE (reset state): cnt_h = cnt_v = 0. All outputs 0.
  - IDLE→RUN: when run=1 is sampled. Counting starts from (0,0) on the next cycle.
  - RUN→IDLE: only when run=0 is sampled at cnt_h=H_TOTAL-1 and cnt_v=V_TOTAL-1. Frames are never truncated; deasserting run mid-frame completes that frame.
- Counting in RUN:
  - cnt_h wraps H_TOTAL-1→0.
  - cnt_v increments on the h-wrap and wraps V_TOTAL-1→0.
- Regions:
  - Sync: cnt_h < H_SYNC (h), cnt_v < V_SYNC (v).
  - Active: H_SYNC+H_BACK ≤ cnt_h < H_SYNC+H_BACK+H_VALID, and the analogous vertical condition.
- Outputs:
  - pix_req is registered from the active-area decode of the counters.
  - pix_x = cnt_h−(H_SYNC+H_BACK) and pix_y = cnt_v−(V_SYNC+V_BACK), registered with pix_req. Both read 0 when pix_req=0.
  - de, hsync and vsync are the pix_req and sync decodes delayed one further cycle, so all three are aligned with rgb.
  - rgb is registered from pix_data when the previous-cycle pix_req=1, otherwise 0. Expansion:
    - r = {p[15:11], p[15:13]}
    - g = {p[10:5], p[10:9]}
    - b = {p[4:0], p[4:2]}
- frame_start: 1 in the cycle after the counters are at (0,0) in RUN, aligned with hsync/vsync.
- active: registered (state==RUN).

## Timing
- Reset values: every output 0, state IDLE.
- Pipeline: counter value → pix_req/pix_x/pix_y (+1 cycle) → de/hsync/vsync/rgb (+2 cycles).
- Renderer contract: fixed 1-cycle read latency, no backpressure. pix_data is sampled exactly 1 cycle after pix_req.
- The encoder adds its own 2-cycle latency downstream. That latency is not compensated here because all encoder inputs stay mutually aligned.
- pix_req per active line: H_VALID consecutive cycles, V_VALID lines per frame.
- First RUN cycle after IDLE: hsync=vsync=1 two cycles after run is sampled.
- Reset mid-frame: all outputs clear immediately and asynchronously. Restart requires run to be sampled again after reset release.
- run toggled high then low within IDLE: a single cycle high is sufficient to start one full frame.

## Configuration
- HDMI_TEST_PATTERN_EN defined:
  - rgb is generated internally as 8 vertical colour bars, each H_VALID/8 pixels wide. Order left to right: white, yellow, cyan, green, magenta, red, blue, black, using 8'hFF/8'h00 components.
  - The bar index comes from a bar-width counter reset at each line's first pixel; no divider is used.
  - pix_data is ignored. pix_req, pix_x and pix_y still behave normally.
  - Timing and latency are identical to normal mode.
- Undefined: rgb is taken from pix_data as described in Operation.

## Test plan
- Reset with run=0 for 100 cycles → all outputs 0, active=0, no pix_req.
- run=1 held, default params → per line:
  - hsync high 96 cycles.
  - de high 640 cycles, starting 144 cycles after the hsync rise.
  - Line period 800 cycles; frame period 420000 cycles.
  - vsync high 1600 cycles.
  - 307200 de cycles per frame.
- Renderer model returns pix_data = {pix_x[4:0], pix_y[5:0], 5'h1F} one cycle after pix_req → rgb matches the expansion at the pixel aligned with de. At pixel (0,0), rgb_b=8'hFF.
- Drop run at mid-frame line 200 → frame completes to cnt (799,524), then active=0. de is never asserted again, and no partial frame occurs.
- Assert sys_rst_n=0 during active video → de/hsync/vsync/rgb=0 in the same cycle. After release with run=1, the next frame_start occurs 2 cycles after run is sampled.
- With HDMI_TEST_PATTERN_EN: pixel 0 → rgb=FF,FF,FF; pixel 80 → FF,FF,00; pixel 639 → 00,00,00.
